// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU select codes, datapath mux codes and the FSM state encoding.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpcRtype  = 6'b000000;
  localparam logic [5:0] OpcRtypeV = 6'b000001;  // R-type, shift amount taken from rs
  localparam logic [5:0] OpcLw     = 6'b100011;
  localparam logic [5:0] OpcSw     = 6'b101011;
  localparam logic [5:0] OpcAddi   = 6'b001000;
  localparam logic [5:0] OpcBeq    = 6'b000100;
  localparam logic [5:0] OpcJ      = 6'b000010;

  // Funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b110000;
  localparam logic [5:0] FnSrl = 6'b110001;
  localparam logic [5:0] FnSra = 6'b110010;

  // ALU select codes
  localparam logic [2:0] AluSelAnd = 3'b000;
  localparam logic [2:0] AluSelOr  = 3'b001;
  localparam logic [2:0] AluSelAdd = 3'b010;
  localparam logic [2:0] AluSelSll = 3'b011;
  localparam logic [2:0] AluSelSrl = 3'b100;
  localparam logic [2:0] AluSelSra = 3'b101;
  localparam logic [2:0] AluSelSub = 3'b110;
  localparam logic [2:0] AluSelSlt = 3'b111;

  // ALU source B mux
  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  // PC source mux
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtEx,
    StAluWb,
    StAddiEx,
    StAddiWb,
    StBranch,
    StJump
  } state_e;

  typedef enum logic [1:0] {
    AluModeAdd,
    AluModeSub,
    AluModeFunct
  } alu_mode_e;

  // True for every opcode the FSM knows how to execute
  function automatic logic opcode_legal(logic [5:0] opc);
    return (opc == OpcRtype) || (opc == OpcRtypeV) || (opc == OpcLw) || (opc == OpcSw) ||
           (opc == OpcAddi) || (opc == OpcBeq) || (opc == OpcJ);
  endfunction

  // True in the last cycle of an instruction; a stalled store has not finished yet
  function automatic logic state_retires(state_e st, logic mem_rdy);
    unique case (st)
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: return 1'b1;
      StMemWr:                                      return mem_rdy;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU select decoder: forced add, forced sub, or decoded from funct.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WL = 6
) (
  input  logic [WL-1:0] funct_i,
  input  alu_mode_e     mode_i,
  output logic [2:0]    alu_sel_o
);

  // Decode mode first; unknown funct codes fall back to add
  always_comb begin
    alu_sel_o = AluSelAdd;
    unique case (mode_i)
      AluModeAdd: alu_sel_o = AluSelAdd;
      AluModeSub: alu_sel_o = AluSelSub;
      AluModeFunct: begin
        case (funct_i)
          FnAdd:   alu_sel_o = AluSelAdd;
          FnSub:   alu_sel_o = AluSelSub;
          FnAnd:   alu_sel_o = AluSelAnd;
          FnOr:    alu_sel_o = AluSelOr;
          FnSlt:   alu_sel_o = AluSelSlt;
          FnSll:   alu_sel_o = AluSelSll;
          FnSrl:   alu_sel_o = AluSelSrl;
          FnSra:   alu_sel_o = AluSelSra;
          default: alu_sel_o = AluSelAdd;
        endcase
      end
      default: alu_sel_o = AluSelAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus a retired-instruction counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WL = 6,
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [WL-1:0] Opcode,
  input  logic [WL-1:0] funct,
  input  logic          Zero,
  input  logic          MemRdy,
  output logic          MemReq,
  output logic          IorD,
  output logic          IRWE,
  output logic          DMWE,
  output logic          RFWE,
  output logic          RFDSel,
  output logic          MtoRFSel,
  output logic          ALUSrcA,
  output logic          shamt_rsSel,
  output logic [1:0]    ALUSrcB,
  output logic [1:0]    PCSrc,
  output logic [2:0]    ALUSel,
  output logic          PCEn,
  output logic          IllegalOp,
  output logic [CW-1:0] RetireCnt
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic      mem_req, iord, irwe, dmwe, rfwe, rfd_sel, mto_rf_sel;
  logic      src_a, shamt_sel, alu_en, pc_en, illegal_op;
  logic [1:0] src_b, pc_src;
  alu_mode_e alu_mode;
  logic [2:0] dec_alu_sel;

  // Next-state and retirement counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFetch:  if (MemRdy) state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpcRtype, OpcRtypeV: state_d = StRtEx;
          OpcLw, OpcSw:        state_d = StMemAdr;
          OpcAddi:             state_d = StAddiEx;
          OpcBeq:              state_d = StBranch;
          OpcJ:                state_d = StJump;
          default:             state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (Opcode == OpcLw) ? StMemRd : StMemWr;
      StMemRd:  if (MemRdy) state_d = StMemWb;
      StMemWr:  if (MemRdy) state_d = StFetch;
      StMemWb:  state_d = StFetch;
      StRtEx:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
    if (state_retires(state_q, MemRdy)) cnt_d = cnt_q + 1'b1;
  end

  // State and counter registers; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    irwe       = 1'b0;
    dmwe       = 1'b0;
    rfwe       = 1'b0;
    rfd_sel    = 1'b0;
    mto_rf_sel = 1'b0;
    src_a      = 1'b0;
    shamt_sel  = 1'b0;
    src_b      = SrcBReg;
    pc_src     = PcSrcAlu;
    alu_en     = 1'b0;
    alu_mode   = AluModeAdd;
    pc_en      = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        src_b   = SrcBFour;
        alu_en  = 1'b1;
        irwe    = MemRdy;
        pc_en   = MemRdy;
      end
      StDecode: begin
        src_b  = SrcBImm;
        alu_en = 1'b1;
      end
      StMemAdr: begin
        src_a  = 1'b1;
        src_b  = SrcBImm;
        alu_en = 1'b1;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        dmwe    = MemRdy;
      end
      StMemWb: begin
        rfwe       = 1'b1;
        mto_rf_sel = 1'b1;
      end
      StRtEx: begin
        src_a     = 1'b1;
        alu_en    = 1'b1;
        alu_mode  = AluModeFunct;
        shamt_sel = (Opcode == OpcRtypeV);
      end
      StAluWb: begin
        rfwe    = 1'b1;
        rfd_sel = 1'b1;
      end
      StAddiEx: begin
        src_a  = 1'b1;
        src_b  = SrcBImm;
        alu_en = 1'b1;
      end
      StAddiWb: rfwe = 1'b1;
      StBranch: begin
        src_a    = 1'b1;
        alu_en   = 1'b1;
        alu_mode = AluModeSub;
        pc_src   = PcSrcAluOut;
        pc_en    = Zero;
      end
      StJump: begin
        pc_src = PcSrcJump;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Illegal opcode is flagged only during the decode cycle
  always_comb begin
    illegal_op = (state_q == StDecode) && !opcode_legal(Opcode);
  end

  alu_decoder #(
    .WL(WL)
  ) u_alu_decoder (
    .funct_i  (funct),
    .mode_i   (alu_mode),
    .alu_sel_o(dec_alu_sel)
  );

  // Enables and requests are held low while reset is asserted
  assign MemReq      = mem_req & RSTn;
  assign IRWE        = irwe & RSTn;
  assign DMWE        = dmwe & RSTn;
  assign RFWE        = rfwe & RSTn;
  assign PCEn        = pc_en & RSTn;
  assign IllegalOp   = illegal_op & RSTn;
  assign IorD        = iord;
  assign RFDSel      = rfd_sel;
  assign MtoRFSel    = mto_rf_sel;
  assign ALUSrcA     = src_a;
  assign shamt_rsSel = shamt_sel;
  assign ALUSrcB     = src_b;
  assign PCSrc       = pc_src;
  assign ALUSel      = alu_en ? dec_alu_sel : 3'b000;
  assign RetireCnt   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-state output model feeds a
// scoreboard queue that is checked every cycle on the falling edge.
module tb_multicycle_control;

  localparam int unsigned WL = 6;
  localparam int unsigned CW = 4;  // small so the wrap is reachable

  typedef enum int unsigned {
    SFetch, SDecode, SMemAdr, SMemRd, SMemWb, SMemWr,
    SRtEx, SAluWb, SAddiEx, SAddiWb, SBranch, SJump
  } st_e;

  typedef struct packed {
    logic [17:0]   outs;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b1;
  logic [WL-1:0] Opcode = '0;
  logic [WL-1:0] funct = '0;
  logic          Zero = 1'b0;
  logic          MemRdy = 1'b0;
  logic          MemReq, IorD, IRWE, DMWE, RFWE, RFDSel, MtoRFSel, ALUSrcA, shamt_rsSel;
  logic [1:0]    ALUSrcB, PCSrc;
  logic [2:0]    ALUSel;
  logic          PCEn, IllegalOp;
  logic [CW-1:0] RetireCnt;

  logic [17:0]   obs;
  logic [CW-1:0] exp_cnt = '0;
  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  multicycle_control #(
    .WL(WL),
    .CW(CW)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Opcode     (Opcode),
    .funct      (funct),
    .Zero       (Zero),
    .MemRdy     (MemRdy),
    .MemReq     (MemReq),
    .IorD       (IorD),
    .IRWE       (IRWE),
    .DMWE       (DMWE),
    .RFWE       (RFWE),
    .RFDSel     (RFDSel),
    .MtoRFSel   (MtoRFSel),
    .ALUSrcA    (ALUSrcA),
    .shamt_rsSel(shamt_rsSel),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUSel     (ALUSel),
    .PCEn       (PCEn),
    .IllegalOp  (IllegalOp),
    .RetireCnt  (RetireCnt)
  );

  always #5 CLK = ~CLK;

  assign obs = {MemReq, IorD, IRWE, DMWE, RFWE, RFDSel, MtoRFSel, ALUSrcA, shamt_rsSel,
                ALUSrcB, PCSrc, ALUSel, PCEn, IllegalOp};

  function automatic logic [2:0] funct_alu(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b110000: return 3'b011;
      6'b110001: return 3'b100;
      6'b110010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle, packed in the same order as obs
  function automatic logic [17:0] model_out(st_e st, logic [5:0] opc, logic [5:0] fn,
                                            logic rdy, logic zero, logic rstn);
    logic mreq, iord, irwe, dmwe, rfwe, rfd, mtorf, sa, sh, pcen, ill;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {mreq, iord, irwe, dmwe, rfwe, rfd, mtorf, sa, sh, pcen, ill} = '0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      SFetch:  begin mreq = 1; sb = 2'b01; alu = 3'b010; irwe = rdy; pcen = rdy; end
      SDecode: begin
        sb = 2'b10; alu = 3'b010;
        ill = !(opc inside {6'b000000, 6'b000001, 6'b100011, 6'b101011,
                            6'b001000, 6'b000100, 6'b000010});
      end
      SMemAdr: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      SMemRd:  begin mreq = 1; iord = 1; end
      SMemWr:  begin mreq = 1; iord = 1; dmwe = rdy; end
      SMemWb:  begin rfwe = 1; mtorf = 1; end
      SRtEx:   begin sa = 1; alu = funct_alu(fn); sh = (opc == 6'b000001); end
      SAluWb:  begin rfwe = 1; rfd = 1; end
      SAddiEx: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      SAddiWb: rfwe = 1;
      SBranch: begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = zero; end
      SJump:   begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    if (!rstn) {mreq, irwe, dmwe, rfwe, pcen, ill} = '0;
    return {mreq, iord, irwe, dmwe, rfwe, rfd, mtorf, sa, sh, sb, pcs, alu, pcen, ill};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, check on the falling edge
  task automatic step(input string tag, input st_e st, input logic rdy, input logic zero,
                      input logic rstn, input bit retire);
    exp_t e;
    RSTn   = rstn;
    MemRdy = rdy;
    Zero   = zero;
    if (!rstn) exp_cnt = '0;
    e.outs = model_out(st, Opcode, funct, rdy, zero, rstn);
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    @(negedge CLK);
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.outs) else begin
      n_fail++;
      $error("FAIL %s outputs: got %b, expected %b", tag, obs, e.outs);
    end
    n_cmp++;
    assert (RetireCnt === e.cnt) else begin
      n_fail++;
      $error("FAIL %s RetireCnt: got %0d, expected %0d", tag, RetireCnt, e.cnt);
    end
    @(posedge CLK);
    #1;
    if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    #1;
    // Reset while FETCH would otherwise request memory
    Opcode = 6'b100011;
    step("reset", SFetch, 1, 0, 0, 0);

    // lw, MemRdy also high in states that must ignore it
    step("lw_fetch", SFetch, 1, 0, 1, 0);
    step("lw_dec", SDecode, 1, 0, 1, 0);
    step("lw_adr", SMemAdr, 1, 0, 1, 0);
    step("lw_rd", SMemRd, 1, 0, 1, 0);
    step("lw_wb", SMemWb, 1, 0, 1, 1);

    // sw with three stall cycles in MEMWR
    Opcode = 6'b101011;
    step("sw_fetch", SFetch, 1, 0, 1, 0);
    step("sw_dec", SDecode, 0, 0, 1, 0);
    step("sw_adr", SMemAdr, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("sw_wait", SMemWr, 0, 0, 1, 0);
    step("sw_wr", SMemWr, 1, 0, 1, 1);

    // R-type add, shift by rs (sra), and unlisted funct
    Opcode = 6'b000000; funct = 6'b100000;
    step("add_fetch", SFetch, 1, 0, 1, 0);
    step("add_dec", SDecode, 0, 0, 1, 0);
    step("add_ex", SRtEx, 0, 0, 1, 0);
    step("add_wb", SAluWb, 0, 0, 1, 1);
    Opcode = 6'b000001; funct = 6'b110010;
    step("srav_fetch", SFetch, 1, 0, 1, 0);
    step("srav_dec", SDecode, 0, 0, 1, 0);
    step("srav_ex", SRtEx, 0, 0, 1, 0);
    step("srav_wb", SAluWb, 0, 0, 1, 1);
    Opcode = 6'b000000; funct = 6'b111111;
    step("badfn_fetch", SFetch, 1, 0, 1, 0);
    step("badfn_dec", SDecode, 0, 0, 1, 0);
    step("badfn_ex", SRtEx, 0, 0, 1, 0);
    step("badfn_wb", SAluWb, 0, 0, 1, 1);
    funct = 6'b101010;
    step("slt_fetch", SFetch, 1, 0, 1, 0);
    step("slt_dec", SDecode, 0, 0, 1, 0);
    step("slt_ex", SRtEx, 0, 0, 1, 0);
    step("slt_wb", SAluWb, 0, 0, 1, 1);

    // addi
    Opcode = 6'b001000;
    step("addi_fetch", SFetch, 1, 0, 1, 0);
    step("addi_dec", SDecode, 0, 0, 1, 0);
    step("addi_ex", SAddiEx, 1, 0, 1, 0);
    step("addi_wb", SAddiWb, 0, 0, 1, 1);

    // beq taken, then not taken
    Opcode = 6'b000100;
    step("beq1_fetch", SFetch, 1, 0, 1, 0);
    step("beq1_dec", SDecode, 0, 1, 1, 0);
    step("beq1_br", SBranch, 0, 1, 1, 1);
    step("beq0_fetch", SFetch, 1, 0, 1, 0);
    step("beq0_dec", SDecode, 0, 0, 1, 0);
    step("beq0_br", SBranch, 1, 0, 1, 1);

    // Illegal opcode: back to FETCH, no retirement
    Opcode = 6'b111111;
    step("ill_fetch", SFetch, 1, 0, 1, 0);
    step("ill_dec", SDecode, 0, 0, 1, 0);
    step("ill_after", SFetch, 0, 0, 1, 0);

    // Reset during a stalled store
    Opcode = 6'b101011;
    step("abt_fetch", SFetch, 1, 0, 1, 0);
    step("abt_dec", SDecode, 0, 0, 1, 0);
    step("abt_adr", SMemAdr, 0, 0, 1, 0);
    step("abt_wait", SMemWr, 0, 0, 1, 0);
    step("abt_rst", SFetch, 1, 0, 0, 0);
    step("abt_rst2", SFetch, 1, 0, 0, 0);

    // 2^CW jumps bring the counter back to zero
    Opcode = 6'b000010;
    for (int i = 0; i < (1 << CW); i++) begin
      step("j_fetch", SFetch, 1, 0, 1, 0);
      step("j_dec", SDecode, 0, 0, 1, 0);
      step("j_jump", SJump, 0, 0, 1, 1);
    end
    step("wrap", SFetch, 0, 0, 1, 0);
    n_cmp++;
    assert (RetireCnt === '0) else begin
      n_fail++;
      $error("FAIL wrap_zero: RetireCnt %0d, expected 0", RetireCnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WL, default 6, meaning the width of Opcode and funct.
REQ-002 SHALL have parameter CW, default 16, meaning the width of RetireCnt.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Opcode, input, WL bits: instr[31:26] from the instruction register.
REQ-006 SHALL have port funct, input, WL bits: instr[5:0] from the instruction register.
REQ-007 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port MemRdy, input, 1 bit: memory access-complete strobe.
REQ-009 SHALL have port MemReq, output, 1 bit: memory access request.
REQ-010 SHALL have port IorD, output, 1 bit: address select (0 = PC, 1 = ALUOut).
REQ-011 SHALL have outputs IRWE, DMWE, RFWE, RFDSel, MtoRFSel, ALUSrcA and shamt_rsSel, each 1 bit: datapath controls.
REQ-012 SHALL have outputs ALUSrcB (2 bits: 00 reg, 01 const 4, 10 signimm) and PCSrc (2 bits: 00 ALU, 01 ALUOut, 10 jump target).
REQ-013 SHALL have output ALUSel, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 srl, 101 sra.
REQ-014 SHALL have output PCEn, 1 bit: PC write enable.
REQ-015 SHALL have outputs IllegalOp (1 bit) and RetireCnt (CW bits): status.

Function
REQ-016 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, ALUWB, ADDIEX, ADDIWB, BRANCH and JUMP.
REQ-017 FETCH SHALL drive MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUSel=010 and PCSrc=00; IRWE and PCEn SHALL equal MemRdy; the FSM SHALL stay in FETCH while MemRdy=0 and go to DECODE when MemRdy=1.
REQ-018 DECODE SHALL drive ALUSrcA=0, ALUSrcB=10 and ALUSel=010 (branch target); the next state SHALL follow Opcode: 000000/000001 -> RTEX, 100011/101011 -> MEMADR, 001000 -> ADDIEX, 000100 -> BRANCH, 000010 -> JUMP, any other value -> FETCH with IllegalOp=1 for that one cycle.
REQ-019 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUSel=010, then go to MEMRD for lw or MEMWR for sw.
REQ-020 MEMRD SHALL drive MemReq=1 and IorD=1, wait for MemRdy, then go to MEMWB.
REQ-021 MEMWR SHALL drive MemReq=1, IorD=1 and DMWE=MemRdy, wait for MemRdy, then go to FETCH.
REQ-022 MEMWB SHALL drive RFWE=1, RFDSel=0 and MtoRFSel=1, then go to FETCH.
REQ-023 RTEX SHALL drive ALUSrcA=1 and ALUSrcB=00, with ALUSel taken from the funct table; shamt_rsSel SHALL be 1 only when Opcode=000001; next state SHALL be ALUWB.
REQ-024 ALUWB SHALL drive RFWE=1, RFDSel=1 and MtoRFSel=0, then go to FETCH.
REQ-025 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUSel=010; ADDIWB SHALL drive RFWE=1, RFDSel=0 and MtoRFSel=0.
REQ-026 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUSel=110, PCSrc=01 and PCEn=Zero, then go to FETCH.
REQ-027 JUMP SHALL drive PCSrc=10 and PCEn=1, then go to FETCH.
REQ-028 The funct table SHALL map 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 110000 sll, 110001 srl and 110010 sra; an unlisted funct SHALL give 010 and no latch.
REQ-029 Any output not listed for a state SHALL be 0; there SHALL be no x values on any output.
REQ-030 Latency with MemRdy tied to 1 SHALL be: lw 5 cycles, sw/R/addi 4 cycles, beq/j 3 cycles.
REQ-031 RetireCnt SHALL increment by 1 on the final state of each legal instruction and wrap from 2^CW-1 to 0; illegal opcodes SHALL NOT count.
REQ-032 MemRdy SHALL be ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-033 RSTn=0 SHALL immediately force state=FETCH and RetireCnt=0.
REQ-034 While RSTn=0, MemReq, IRWE, DMWE, RFWE, PCEn and IllegalOp SHALL be forced to 0.
REQ-035 Reset asserted mid-instruction, including while waiting in MEMWR, SHALL abort with no further write enable.
REQ-036 After RSTn deasserts, the first active cycle SHALL be FETCH.

Structure
REQ-037 A shared package mips_ctrl_pkg SHALL hold the opcode constants, funct constants, ALUSel codes and state encoding.
REQ-038 The design SHALL contain exactly one sub-module, alu_decoder (combinational: funct plus a mode select of add, sub or funct -> ALUSel).
REQ-039 The state register SHALL be the only storage besides RetireCnt.

Verification
REQ-040 lw with MemRdy=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RFWE=1 only in cycle 5; RetireCnt 0 -> 1.
REQ-041 sw with MemRdy held low 3 cycles in MEMWR: FSM stays in MEMWR; DMWE=1 in exactly one cycle, coincident with MemRdy.
REQ-042 beq with Zero=1, then beq with Zero=0: PCEn=1 in BRANCH for the first, PCEn=0 for the second; ALUSel=110.
REQ-043 Opcode=000001 with funct=110010: shamt_rsSel=1 and ALUSel=101 in RTEX; Opcode=000000 with funct=111111: ALUSel=010.
REQ-044 Opcode=111111: DECODE -> FETCH; IllegalOp pulses 1 cycle; RetireCnt unchanged.
REQ-045 RSTn low during MEMWR before MemRdy: DMWE never 1; state is FETCH after release; 2^CW instructions later RetireCnt wraps to 0.
